// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage CPU: load-use stalls, taken-branch squash and
// data-memory wait states, plus a saturating count of cycles where the PC is held.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned RA_W         = 5,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [RA_W-1:0]  id_rs1_i,
  input  logic [RA_W-1:0]  id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [RA_W-1:0]  ex_rd_i,
  input  logic             ex_memtoreg_i,
  input  logic             ex_regwrite_i,
  input  logic             ex_br_taken_i,
  input  logic             dmem_busy_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_freeze_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StFlush   = 2'd2,
    StMemWait = 2'd3
  } state_t;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  state_t           eff_state;
  logic [FcW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;

  assign load_use = ex_memtoreg_i & ex_regwrite_i & (ex_rd_i != '0) &
                    ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                     (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

  // When memory becomes ready, the same cycle behaves as the state we returned to.
  assign eff_state = ((state_q == StMemWait) && !dmem_busy_i) ? ret_q : state_q;

  always_comb begin
    pc_we_o       = 1'b1;
    ifid_we_o     = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;
    state_d       = state_q;
    ret_d         = ret_q;
    flush_cnt_d   = flush_cnt_q;

    if (dmem_busy_i) begin
      pc_we_o       = 1'b0;
      ifid_we_o     = 1'b0;
      pipe_freeze_o = 1'b1;
      state_d       = StMemWait;
      if (state_q != StMemWait) ret_d = state_q;
    end else begin
      case (eff_state)
        StFlush: begin
          ifid_flush_o  = 1'b1;
          idex_bubble_o = 1'b1;
          flush_cnt_d   = flush_cnt_q - FcW'(1);
          state_d       = (flush_cnt_q == FcW'(1)) ? StRun : StFlush;
        end
        default: begin
          state_d = StRun;
          if (ex_br_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              flush_cnt_d = FcW'(FLUSH_CYCLES - 1);
              state_d     = StFlush;
            end
          end else if (load_use) begin
            pc_we_o       = 1'b0;
            ifid_we_o     = 1'b0;
            idex_bubble_o = 1'b1;
          end
        end
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_we_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StRun;
      ret_q       <= StRun;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
